// File: rtl/exec_replica_monitor.sv
// Launch/capture timing-error monitor for the execute-stage delay replica.
// Define EXEC_REPLICA_MON_THROTTLE_EN to enable windowed throttling (stall_req_o/stall_ack_i).
module exec_replica_monitor #(
   parameter int ERR_THRESH      = 4,
   parameter int WINDOW_LOG2     = 8,
   parameter int HOLD_CYCLES     = 16,
   parameter int CNT_W           = 16,
   parameter bit REPLICA_INVERTS = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             clear_i,
   output logic             replica_launch_o,
   input  logic             replica_capture_i,
   output logic             timing_err_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic             stall_req_o,
   input  logic             stall_ack_i
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
      return v;
   endfunction

   logic             launch_p0, vld_p0;
   logic             capture_p1, expect_p1, vld_p1;
   logic             err_p2;
   logic [CNT_W-1:0] err_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         launch_p0  <= 1'b0;
         vld_p0     <= 1'b0;
         capture_p1 <= 1'b0;
         expect_p1  <= 1'b0;
         vld_p1     <= 1'b0;
         err_p2     <= 1'b0;
         err_cnt    <= '0;
      end else begin
         // p0: launch into the replica chain
         if (enable_i) launch_p0 <= ~launch_p0;
         vld_p0 <= enable_i;
         // p1: capture the chain output; capture_p1 is the only flop exposed to the async path
         capture_p1 <= replica_capture_i;
         expect_p1  <= launch_p0 ^ REPLICA_INVERTS;
         vld_p1     <= vld_p0;
         // p2: compare and accumulate
         err_p2  <= vld_p1 & (capture_p1 ^ expect_p1);
         err_cnt <= clear_i ? '0 : sat_inc(err_cnt, err_p2);
      end
   end

   assign replica_launch_o = launch_p0;
   assign timing_err_o     = err_p2;
   assign err_count_o      = err_cnt;

`ifdef EXEC_REPLICA_MON_THROTTLE_EN
   localparam int WE_W   = WINDOW_LOG2 + 1;
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, REQ, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [WINDOW_LOG2-1:0] win_ctr;
   logic [WE_W-1:0]        win_err, win_err_inc;
   logic [HOLD_W-1:0]      hold_cnt;
   logic                   win_wrap;
   logic                   stall_q;

   // An error landing on the wrap cycle is the first error of the new window.
   assign win_wrap    = (win_ctr == {WINDOW_LOG2{1'b1}});
   assign win_err_inc = win_wrap ? WE_W'(1) : win_err + WE_W'(1);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (enable_i) state_nxt = RUN;
         RUN: begin
            if (err_p2 && (win_err_inc >= WE_W'(ERR_THRESH))) state_nxt = REQ;
            else if (!enable_i)                               state_nxt = IDLE;
         end
         REQ:  if (stall_ack_i) state_nxt = HOLD;
         HOLD: if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) state_nxt = enable_i ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         stall_q  <= 1'b0;
         hold_cnt <= '0;
         win_ctr  <= '0;
         win_err  <= '0;
      end else begin
         state    <= state_nxt;
         stall_q  <= (state_nxt == REQ) || (state_nxt == HOLD);
         hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
         // Window only advances while staying in RUN; any other path restarts it.
         if ((state == RUN) && (state_nxt == RUN)) begin
            win_ctr <= win_ctr + WINDOW_LOG2'(1);
            win_err <= win_wrap ? WE_W'(err_p2) : win_err + WE_W'(err_p2);
         end else begin
            win_ctr <= '0;
            win_err <= '0;
         end
      end
   end

   assign stall_req_o = stall_q;
`else
   logic unused_ok;
   assign unused_ok   = stall_ack_i ^ ((ERR_THRESH + WINDOW_LOG2 + HOLD_CYCLES) > 0);
   assign stall_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_exec_replica_monitor.sv
// Directed bench for exec_replica_monitor: error detection, counting, saturation, throttle handshake.
module tb_exec_replica_monitor;

`ifdef EXEC_REPLICA_MON_THROTTLE_EN
   localparam logic THR = 1'b1;
`else
   localparam logic THR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, enable, clear, stuck, flip, ack;
   logic       launch, capture, terr, stall;
   logic [3:0] errcnt;

   int n_chk  = 0;
   int n_pass = 0;
   int stall_hi;

   always #5 clk = ~clk;

   // Ideal non-inverting replica, optionally stuck at 0 or flipped for error injection.
   assign capture = stuck ? 1'b0 : (launch ^ flip);

   exec_replica_monitor #(
      .ERR_THRESH(4), .WINDOW_LOG2(8), .HOLD_CYCLES(16), .CNT_W(4), .REPLICA_INVERTS(1'b0)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
      .replica_launch_o(launch), .replica_capture_i(capture),
      .timing_err_o(terr), .err_count_o(errcnt),
      .stall_req_o(stall), .stall_ack_i(ack)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (stall) stall_hi++;
      end
   endtask

   task automatic inject(input int n);
      flip = 1'b1;
      step(n);
      flip = 1'b0;
      step(3);
   endtask

   task automatic do_reset();
      enable = 1'b0; stuck = 1'b0; flip = 1'b0; ack = 1'b0; clear = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   initial begin
      int bad, tog_bad, stall_bad;
      logic prev;
      rst = 1'b1; enable = 1'b0; clear = 1'b0; stuck = 1'b0; flip = 1'b0; ack = 1'b0;
      step(2);
      chk("rst_launch", launch, 0);
      chk("rst_err", terr, 0);
      chk("rst_cnt", errcnt, 0);
      chk("rst_stall", stall, 0);
      rst = 1'b0;
      step(1);

      // ideal wire for 100 cycles
      enable = 1'b1; bad = 0; tog_bad = 0; stall_bad = 0; prev = launch;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (terr) bad++;
         if (stall) stall_bad++;
         if (launch == prev) tog_bad++;
         prev = launch;
      end
      chk("wire_err", bad, 0);
      chk("wire_toggle", tog_bad, 0);
      chk("wire_cnt", errcnt, 0);
      chk("wire_stall", stall_bad, 0);

      // stuck-at-0: errors on every launched 1, stall after the 4th
      do_reset();
      stuck = 1'b1; enable = 1'b1;
      step(1); chk("st_launch_e1", launch, 1); chk("st_err_e1", terr, 0);
      step(1); chk("st_err_e2", terr, 0);
      step(1); chk("st_err_e3", terr, 1); chk("st_cnt_e3", errcnt, 0);
      step(1); chk("st_err_e4", terr, 0); chk("st_cnt_e4", errcnt, 1);
      step(5); chk("st_err_e9", terr, 1); chk("st_cnt_e9", errcnt, 3); chk("st_stall_e9", stall, 0);
      step(1); chk("st_stall_e10", stall, THR); chk("st_cnt_e10", errcnt, 4);
      stuck = 1'b0;

      // ack 5 cycles after request, release 16 edges after ack sampled
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (stall !== THR) bad++;
      end
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      if (stall !== THR) bad++;
      chk("req_wait", bad, 0);
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (stall !== THR) bad++;
      end
      chk("hold_high", bad, 0);
      step(1); chk("hold_fall", stall, 0);
      chk("req_cnt", errcnt, 5);

      // window restarted from 0: three errors no stall, fourth stalls
      stall_hi = 0;
      repeat (3) inject(1);
      chk("win_clr_nostall", stall_hi, 0);
      chk("win_clr_cnt", errcnt, 8);
      flip = 1'b1; step(1); flip = 1'b0;
      step(1); chk("thr_err", terr, 1); chk("thr_stall_pre", stall, 0);
      step(1); chk("thr_stall", stall, THR); chk("thr_cnt", errcnt, 9);

      // async reset while in HOLD
      ack = 1'b1; step(1); ack = 1'b0;
      step(3);
      chk("pre_rst_stall", stall, THR);
      chk("pre_rst_cnt", errcnt, 9);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_err", terr, 0);
      chk("mid_rst_cnt", errcnt, 0);
      chk("mid_rst_launch", launch, 0);
      stuck = 1'b1; enable = 1'b1;
      step(1);
      rst = 1'b0;
      step(1); chk("rec_err_e1", terr, 0); chk("rec_launch_e1", launch, 1);
      step(1); chk("rec_err_e2", terr, 0);
      step(1); chk("rec_err_e3", terr, 1);

      // three errors, window wrap, one more: no stall
      do_reset();
      enable = 1'b1;
      step(2);
      stall_hi = 0;
      repeat (3) inject(1);
      step(300);
      inject(1);
      chk("wrap_nostall", stall_hi, 0);
      chk("wrap_cnt", errcnt, 4);

      // saturation and clear priority
      do_reset();
      enable = 1'b1;
      step(2);
      inject(15);
      chk("sat_pre", errcnt, 15);
      flip = 1'b1; step(1); flip = 1'b0;
      step(1); chk("clr_err", terr, 1);
      clear = 1'b1; step(1); clear = 1'b0;
      chk("clr_wins", errcnt, 0);
      inject(15);
      chk("sat_refill", errcnt, 15);
      inject(1);
      chk("sat_hold", errcnt, 15);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/exec_replica_monitor.md
# exec_replica_monitor

Launch/capture monitor at the receiving end of the execute-stage delay replica. It toggles a launch flop into the replica chain every cycle and captures the chain output one clock later. A mismatch against the launched value means the critical path is failing at the current clock/voltage. The block counts these timing errors and, past a per-window threshold, requests a pipeline stall from the core through a req/ack handshake.

## Interface
Parameters:
- ERR_THRESH, 4 — errors within one window that trigger a throttle request (1..2^WINDOW_LOG2).
- WINDOW_LOG2, 8 — observation window length = 2^WINDOW_LOG2 cycles.
- HOLD_CYCLES, 16 — cycles stall_req_o stays high after stall_ack_i (≥1).
- CNT_W, 16 — width of the total error counter.
- REPLICA_INVERTS, 0 — 1 if the replica chain has odd inversion parity.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- enable_i  in  1  monitoring enable.
- clear_i  in  1  synchronous clear of err_count_o.
- replica_launch_o  out  1  drives replica chain input (registered).
- replica_capture_i  in  1  replica chain output.
- timing_err_o  out  1  one-cycle pulse per detected error (registered).
- err_count_o  out  CNT_W  saturating total error count.
- stall_req_o  out  1  throttle request to core.
- stall_ack_i  in  1  core acknowledges stall.

## Operation
- Reset: all outputs 0; FSM=IDLE; launch, capture, expect, valid, window and hold counters 0.
- Launch: while enable_i=1, replica_launch_o toggles every edge; launch_vld_q <= enable_i.
- Capture, edge n+1: capture_q <= replica_capture_i; expect_q <= replica_launch_o ^ REPLICA_INVERTS; cmp_vld_q <= launch_vld_q.
- Compare, edge n+2: timing_err_o <= cmp_vld_q & (capture_q ^ expect_q).
- The first compare after enable_i rises is suppressed because the valid pipeline starts at 0. Compares stop two cycles after enable_i falls.
- err_count_o increments on each timing_err_o pulse and saturates at 2^CNT_W−1. clear_i forces it to 0 and wins over a simultaneous increment.
- Window: in RUN, a free-running WINDOW_LOG2-bit counter runs alongside a window error count. At wrap, the window count resets to 0. An error on the wrap cycle counts as 1 in the new window.
- FSM:
  - IDLE → RUN when enable_i=1.
  - RUN → IDLE when enable_i=0 (window state cleared).
  - RUN → REQ when the window error count reaches ERR_THRESH, in the same cycle as the threshold-reaching error.
  - REQ: stall_req_o=1; → HOLD when stall_ack_i=1.
  - HOLD: stall_req_o=1 for HOLD_CYCLES cycles, then → RUN with window counters cleared.
- REQ and HOLD complete even if enable_i falls. On completion, go to IDLE if enable_i=0. Errors during REQ/HOLD update err_count_o but not the window count.
- Reset mid-operation returns everything to reset values immediately.

## Timing
- Error latency: launch toggle at edge n → timing_err_o at edge n+2, visible during cycle n+2.
- stall_req_o is registered. It rises one edge after the threshold-reaching timing_err_o pulse.
- stall_ack_i is sampled at each edge in REQ. stall_req_o falls exactly HOLD_CYCLES edges after the edge where ack was sampled.
- replica_capture_i is asynchronous to the launch edge by design. capture_q absorbs the timing-violation risk; no synchronizer is added.

## Configuration
- Macro EXEC_REPLICA_MON_THROTTLE_EN.
- Defined: window counting, FSM REQ/HOLD and stall_req_o behave as above.
- Undefined: window logic and REQ/HOLD are omitted and stall_req_o is tied 0. Launch, capture, timing_err_o and err_count_o are unchanged.

## Test plan
- Replica modeled as an ideal non-inverting wire, enable_i=1 for 100 cycles -> timing_err_o never pulses; err_count_o=0; stall_req_o=0.
- Replica output forced to stuck-at-0 -> timing_err_o pulses on every cycle when the launched value was 1, with the first pulse 2 edges after that launch. err_count_o increments accordingly. stall_req_o rises 1 edge after the 4th error.
- REQ with stall_ack_i asserted 5 cycles after stall_req_o rises -> stall_req_o stays high through the wait, then falls exactly 16 edges after ack is sampled. FSM returns to RUN with the window count at 0.
- 3 errors injected, then window wrap (256 cycles), then 1 more error -> no stall_req_o; err_count_o=4.
- err_count_o preset near saturation (CNT_W=4, 15 errors), 1 further error with clear_i asserted in the same cycle -> err_count_o=0. Same error without clear_i -> err_count_o stays at 15.
- rst_i asserted during HOLD -> stall_req_o, timing_err_o, err_count_o and replica_launch_o go to 0 immediately. After release with enable_i=1, the first possible error appears no earlier than 2 edges after the first launch toggle.
